// File: rtl/key_entry_buffer.sv
// key_entry_buffer: turns keypad presses into hex entry words (E = backspace,
// F = commit) and queues committed words in a small FIFO feeding the display path.
module key_entry_buffer #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned FIFO_AW   = 2,
    parameter logic [3:0]  BKSP_KEY  = 4'hE,
    parameter logic [3:0]  ENTER_KEY = 4'hF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [3:0]                   key,
    input  logic                         key_was_pressed,
    output logic [4*DIGITS-1:0]          entry,
    output logic [$clog2(DIGITS+1)-1:0]  entry_len,
    output logic [4*DIGITS-1:0]          out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FIFO_AW:0]             fifo_level,
    output logic                         err
);

    localparam int unsigned EW    = 4 * DIGITS;
    localparam int unsigned LW    = $clog2(DIGITS + 1);
    localparam int unsigned VW    = FIFO_AW + 1;
    localparam int unsigned DEPTH = 2 ** FIFO_AW;

    logic [EW-1:0]      mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;

    logic [EW-1:0]      entry_nxt;
    logic [LW-1:0]      len_nxt;
    logic               err_nxt;
    logic               push;
    logic               pop;
    logic               full;

    // FIFO head is presented straight from registered state
    assign out_valid = (fifo_level != '0);
    assign out_data  = mem[rd_ptr];
    assign full      = (fifo_level == VW'(DEPTH));
    assign pop       = out_valid & out_ready;

    // Decode the key pulse into the next entry, error flag and push request
    always_comb begin
        entry_nxt = entry;
        len_nxt   = entry_len;
        err_nxt   = 1'b0;
        push      = 1'b0;
        if (key_was_pressed) begin
            if (key == BKSP_KEY) begin
                if (entry_len != '0) begin
                    entry_nxt = entry >> 4;
                    len_nxt   = entry_len - LW'(1);
                end else begin
                    err_nxt = 1'b1;
                end
            end else if (key == ENTER_KEY) begin
                // Full is judged on the registered level; a same-cycle pop does not help
                if (entry_len == '0 || full) begin
                    err_nxt = 1'b1;
                end else begin
                    push      = 1'b1;
                    entry_nxt = '0;
                    len_nxt   = '0;
                end
            end else begin
                if (entry_len < LW'(DIGITS)) begin
                    entry_nxt = EW'({entry, key});
                    len_nxt   = entry_len + LW'(1);
                end else begin
                    err_nxt = 1'b1;
                end
            end
        end
    end

    // Entry, error and FIFO bookkeeping registers
    always_ff @(posedge clk) begin
        if (rst) begin
            entry      <= '0;
            entry_len  <= '0;
            err        <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            entry     <= entry_nxt;
            entry_len <= len_nxt;
            err       <= err_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + VW'(1);
                2'b01:   fifo_level <= fifo_level - VW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // FIFO storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= entry;
        end
    end

endmodule

// File: tb/tb_key_entry_buffer.sv
// Self-checking bench for key_entry_buffer: directed vector table, a head-stability
// sequence, then random presses compared against a queue-based model.
module tb_key_entry_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        kp;
    logic [3:0]  key;
    logic        rdy;
    logic [15:0] entry;
    logic [2:0]  entry_len;
    logic [15:0] out_data;
    logic        out_valid;
    logic [2:0]  fifo_level;
    logic        err;

    always #5 clk = ~clk;

    key_entry_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .key             (key),
        .key_was_pressed (kp),
        .entry           (entry),
        .entry_len       (entry_len),
        .out_data        (out_data),
        .out_valid       (out_valid),
        .out_ready       (rdy),
        .fifo_level      (fifo_level),
        .err             (err)
    );

    typedef struct {
        logic        r;
        logic        k;
        logic [3:0]  c;
        logic        y;
        logic [15:0] e_entry;
        int          e_len;
        logic        e_err;
        logic        e_valid;
        int          e_level;
        logic [15:0] e_data;
    } vec_t;

    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model state: typed digits (oldest first) and committed words
    logic [3:0]  dq[$];
    logic [15:0] fq[$];
    logic        m_err;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void add(input logic r, input logic k, input logic [3:0] c, input logic y,
                                input logic [15:0] ee, input int el, input logic er,
                                input logic ev, input int elv, input logic [15:0] ed);
        vec_t v;
        v.r = r; v.k = k; v.c = c; v.y = y;
        v.e_entry = ee; v.e_len = el; v.e_err = er;
        v.e_valid = ev; v.e_level = elv; v.e_data = ed;
        tbl.push_back(v);
    endfunction

    task automatic drive(input logic r, input logic k, input logic [3:0] c, input logic y);
        @(negedge clk);
        rst = r; kp = k; key = c; rdy = y;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] m_entry();
        logic [15:0] v = '0;
        foreach (dq[i]) v = (v << 4) | 16'(dq[i]);
        return v;
    endfunction

    // One clock of the behaviour, applied to the pre-edge model state
    function automatic void model(input logic r, input logic k, input logic [3:0] c, input logic y);
        bit          full;
        logic [15:0] w;
        m_err = 1'b0;
        if (r) begin
            dq.delete();
            fq.delete();
            return;
        end
        full = (fq.size() == 4);
        w    = m_entry();
        if (fq.size() != 0 && y) void'(fq.pop_front());
        if (k) begin
            if (c == 4'hE) begin
                if (dq.size() == 0) m_err = 1'b1;
                else void'(dq.pop_back());
            end else if (c == 4'hF) begin
                if (dq.size() == 0 || full) m_err = 1'b1;
                else begin
                    fq.push_back(w);
                    dq.delete();
                end
            end else begin
                if (dq.size() == 4) m_err = 1'b1;
                else dq.push_back(c);
            end
        end
    endfunction

    initial begin
        rst = 1'b1; kp = 1'b0; key = 4'h0; rdy = 1'b0;

        // Digits accumulate right-aligned
        add(1,0,0,0, 16'h0000,0,0, 0,0,0);
        add(0,1,1,0, 16'h0001,1,0, 0,0,0);
        add(0,1,2,0, 16'h0012,2,0, 0,0,0);
        add(0,1,3,0, 16'h0123,3,0, 0,0,0);
        // Overflow press, then backspaces down to an empty-entry error
        add(1,0,0,0, 16'h0000,0,0, 0,0,0);
        add(0,1,4'hA,0, 16'h000A,1,0, 0,0,0);
        add(0,1,4'hB,0, 16'h00AB,2,0, 0,0,0);
        add(0,1,4'hC,0, 16'h0ABC,3,0, 0,0,0);
        add(0,1,4'hD,0, 16'hABCD,4,0, 0,0,0);
        add(0,1,4'h7,0, 16'hABCD,4,1, 0,0,0);
        add(0,0,0,0,    16'hABCD,4,0, 0,0,0);
        add(0,1,4'hE,0, 16'h0ABC,3,0, 0,0,0);
        add(0,1,4'hE,0, 16'h00AB,2,0, 0,0,0);
        add(0,1,4'hE,0, 16'h000A,1,0, 0,0,0);
        add(0,1,4'hE,0, 16'h0000,0,0, 0,0,0);
        add(0,1,4'hE,0, 16'h0000,0,1, 0,0,0);
        // Commit, then commit on an empty entry
        add(0,1,4'h5,0, 16'h0005,1,0, 0,0,0);
        add(0,1,4'hF,0, 16'h0000,0,0, 1,1,16'h0005);
        add(0,1,4'hF,0, 16'h0000,0,1, 1,1,16'h0005);
        add(0,0,0,0,    16'h0000,0,0, 1,1,16'h0005);
        // Fill the FIFO, reject a commit when full, then drain in order
        add(1,0,0,0, 16'h0000,0,0, 0,0,0);
        for (int d = 1; d <= 4; d++) begin
            add(0,1,4'(d),0, 16'(d),1,0, d > 1,d-1,16'h0001);
            add(0,1,4'hF,0,  16'h0000,0,0, 1,d,16'h0001);
        end
        add(0,1,4'h9,0, 16'h0009,1,0, 1,4,16'h0001);
        add(0,1,4'hF,0, 16'h0009,1,1, 1,4,16'h0001);
        add(0,0,0,1,    16'h0009,1,0, 1,3,16'h0002);
        add(0,0,0,1,    16'h0009,1,0, 1,2,16'h0003);
        add(0,0,0,1,    16'h0009,1,0, 1,1,16'h0004);
        add(0,0,0,1,    16'h0009,1,0, 0,0,0);
        // Push and pop in the same cycle keep the level
        add(1,0,0,0, 16'h0000,0,0, 0,0,0);
        add(0,1,4'h1,0, 16'h0001,1,0, 0,0,0);
        add(0,1,4'hF,0, 16'h0000,0,0, 1,1,16'h0001);
        add(0,1,4'h2,0, 16'h0002,1,0, 1,1,16'h0001);
        add(0,1,4'hF,0, 16'h0000,0,0, 1,2,16'h0001);
        add(0,1,4'h4,0, 16'h0004,1,0, 1,2,16'h0001);
        add(0,1,4'h2,0, 16'h0042,2,0, 1,2,16'h0001);
        add(0,1,4'hF,1, 16'h0000,0,0, 1,2,16'h0002);
        add(0,0,0,1,    16'h0000,0,0, 1,1,16'h0042);
        add(0,0,0,1,    16'h0000,0,0, 0,0,0);
        // Full FIFO with a pop in the same cycle still rejects the commit
        for (int d = 1; d <= 4; d++) begin
            add(0,1,4'(d),0, 16'(d),1,0, d > 1,d-1,16'h0001);
            add(0,1,4'hF,0,  16'h0000,0,0, 1,d,16'h0001);
        end
        add(0,1,4'h7,0, 16'h0007,1,0, 1,4,16'h0001);
        add(0,1,4'hF,1, 16'h0007,1,1, 1,3,16'h0002);
        add(0,0,0,0,    16'h0007,1,0, 1,3,16'h0002);
        // Reset mid-operation with a coincident key pulse
        add(1,0,0,0, 16'h0000,0,0, 0,0,0);
        add(0,1,4'h8,0, 16'h0008,1,0, 0,0,0);
        add(0,1,4'h8,0, 16'h0088,2,0, 0,0,0);
        add(0,1,4'hF,0, 16'h0000,0,0, 1,1,16'h0088);
        add(0,1,4'h3,0, 16'h0003,1,0, 1,1,16'h0088);
        add(1,1,4'h5,0, 16'h0000,0,0, 0,0,0);
        add(0,0,0,0,    16'h0000,0,0, 0,0,0);

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].k, tbl[i].c, tbl[i].y);
            chk($sformatf("v%0d entry", i), int'(entry), int'(tbl[i].e_entry));
            chk($sformatf("v%0d entry_len", i), int'(entry_len), tbl[i].e_len);
            chk($sformatf("v%0d err", i), int'(err), int'(tbl[i].e_err));
            chk($sformatf("v%0d out_valid", i), int'(out_valid), int'(tbl[i].e_valid));
            chk($sformatf("v%0d fifo_level", i), int'(fifo_level), tbl[i].e_level);
            if (tbl[i].e_valid)
                chk($sformatf("v%0d out_data", i), int'(out_data), int'(tbl[i].e_data));
        end

        // Head word must hold while stalled, even as more words arrive behind it
        drive(1,0,0,0);
        drive(0,1,4'h3,0);
        drive(0,1,4'h1,0);
        drive(0,1,4'hF,0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) drive(0,1,4'h6,0);
            else if (i == 2) drive(0,1,4'hF,0);
            else drive(0,0,0,0);
            chk($sformatf("hold%0d out_data", i), int'(out_data), 16'h0031);
            chk($sformatf("hold%0d out_valid", i), int'(out_valid), 1);
        end
        chk("hold fifo_level", int'(fifo_level), 2);

        // Random presses against the model
        model(1'b1, 1'b0, 4'h0, 1'b0);
        drive(1,0,0,0);
        for (int n = 0; n < 2000; n++) begin
            logic       r, k, y;
            logic [3:0] c;
            int         sel;
            r   = ($urandom_range(0, 299) == 0);
            k   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            c   = (sel < 2) ? 4'hE : (sel < 4) ? 4'hF : 4'($urandom_range(0, 13));
            y   = ($urandom_range(0, 3) == 0);
            model(r, k, c, y);
            drive(r, k, c, y);
            chk($sformatf("r%0d entry", n), int'(entry), int'(m_entry()));
            chk($sformatf("r%0d entry_len", n), int'(entry_len), dq.size());
            chk($sformatf("r%0d err", n), int'(err), int'(m_err));
            chk($sformatf("r%0d out_valid", n), int'(out_valid), int'(fq.size() != 0));
            chk($sformatf("r%0d fifo_level", n), int'(fifo_level), fq.size());
            if (fq.size() != 0)
                chk($sformatf("r%0d out_data", n), int'(out_data), int'(fq[0]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
